// File: rtl/sub_share_ctrl_if.sv
// Bus bundle for sub_share_ctrl: requester handshake, subtracter link, result and status.
interface sub_share_ctrl_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic             enable;
  logic             drain;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_a;
  logic [8*N-1:0]   req_b;
  logic [N-1:0]     gnt;
  logic [7:0]       sub_a;
  logic [7:0]       sub_b;
  logic [8:0]       sub_result;
  logic             res_valid;
  logic [IDW-1:0]   res_id;
  logic [8:0]       res_data;
  logic [IDW+1:0]   inflight;
  logic             idle;

  // Environment side: requesters, sequencer and the attached subtracter
  modport master (
    output enable, drain, req, req_a, req_b, sub_result,
    input  gnt, sub_a, sub_b, res_valid, res_id, res_data, inflight, idle
  );

  // Controller side
  modport slave (
    input  enable, drain, req, req_a, req_b, sub_result,
    output gnt, sub_a, sub_b, res_valid, res_id, res_data, inflight, idle
  );
endinterface

// File: rtl/sub_share_ctrl.sv
// Round-robin sharing of one fixed-latency 8-bit subtracter among N requesters,
// with a tag pipeline returning each result alongside its requester ID.
module sub_share_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned SUB_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  sub_share_ctrl_if.slave bus
);
  localparam int unsigned CW = IDW + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [IDW-1:0]            ptr_q, ptr_d;
  logic [SUB_LAT:0]          tag_vld_q, tag_vld_d;
  logic [SUB_LAT:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [7:0]                sub_a_q, sub_a_d;
  logic [7:0]                sub_b_q, sub_b_d;
  logic                      res_valid_q, res_valid_d;
  logic [IDW-1:0]            res_id_q, res_id_d;
  logic [8:0]                res_data_q, res_data_d;
  logic [CW-1:0]             inflight_q, inflight_d;
  logic                      idle_q, idle_d;

  logic                      grant;
  logic [IDW-1:0]            grant_idx;
  logic [IDW-1:0]            cand;
  logic [N-1:0]              gnt;

  // Round-robin search from ptr; issue only in RUN, and drain/reset win over any request
  always_comb begin
    grant     = 1'b0;
    grant_idx = ptr_q;
    cand      = '0;
    for (int unsigned o = 0; o < N; o++) begin
      cand = IDW'((32'(ptr_q) + o) % N);
      if (!grant && bus.req[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
    if (state_q != StRun || bus.drain || rst) begin
      grant = 1'b0;
    end
    gnt = '0;
    if (grant) begin
      gnt[grant_idx] = 1'b1;
    end
  end

  // Next state for operands, tag pipeline, result registers, counter and FSM
  always_comb begin
    ptr_d   = ptr_q;
    sub_a_d = sub_a_q;
    sub_b_d = sub_b_q;
    if (grant) begin
      ptr_d   = IDW'((32'(grant_idx) + 1) % N);
      sub_a_d = bus.req_a[{grant_idx, 3'b000} +: 8];
      sub_b_d = bus.req_b[{grant_idx, 3'b000} +: 8];
    end

    // Stage 0 travels with sub_a/sub_b, stage SUB_LAT lines up with sub_result
    tag_vld_d = {tag_vld_q[SUB_LAT-1:0], grant};
    tag_id_d  = {tag_id_q[SUB_LAT-1:0], grant_idx};

    res_valid_d = tag_vld_q[SUB_LAT];
    res_id_d    = tag_vld_q[SUB_LAT] ? tag_id_q[SUB_LAT] : res_id_q;
    res_data_d  = tag_vld_q[SUB_LAT] ? bus.sub_result : res_data_q;

    inflight_d = inflight_q + CW'(grant) - CW'(res_valid_q);

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.enable) state_d = StRun;
      StRun:   if (bus.drain) state_d = StDrain;
      StDrain: if (inflight_q == '0 && tag_vld_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    idle_d = (state_d == StIdle);
  end

  // State and registered outputs; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      inflight_q  <= '0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      sub_a_q     <= sub_a_d;
      sub_b_q     <= sub_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      inflight_q  <= inflight_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.sub_a     = sub_a_q;
  assign bus.sub_b     = sub_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign bus.inflight  = inflight_q;
  assign bus.idle      = idle_q;
endmodule
